// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the four-agent PCI request arbiter.
package pci_arb_pkg;

  localparam int unsigned NUM_AGENTS          = 4;
  localparam int unsigned IDX_W               = 2;
  localparam int unsigned GNT_TIMEOUT_DEFAULT = 16;
  // Wide enough for the largest legal GNT_TIMEOUT (31).
  localparam int unsigned CNT_W               = 5;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin finder: first active request after `last`, wrapping back to `last`.
module rr_pick4
  import pci_arb_pkg::*;
(
  input  logic [NUM_AGENTS-1:0] req,
  input  logic [IDX_W-1:0]      last,
  output logic [IDX_W-1:0]      winner,
  output logic                  any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = last;
    any    = 1'b0;
    cand   = '0;
    // Offset NUM_AGENTS wraps to `last` itself, so the previous owner is scanned last.
    for (int unsigned k = 1; k <= NUM_AGENTS; k++) begin
      cand = last + IDX_W'(k);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_req_arbiter.sv
// Four-agent PCI REQ#/GNT# arbiter with round-robin fairness and unused-grant timeout.
// Optional bus parking in IDLE is enabled by defining PCI_ARB_PARK_EN.
module pci_req_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = GNT_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_AGENTS-1:0] req_n,
  input  logic                  frame_n,
  input  logic                  irdy_n,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  gnt_valid,
  output logic                  bus_busy
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             bus_busy_q, bus_busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             release_grant;

  logic [IDX_W-1:0] winner;
  logic             any_req;

  rr_pick4 u_pick (
    .req    (~req_n),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

`ifdef PCI_ARB_PARK_EN
  // Parking target: agent 0 out of reset, then the most recent owner.
  logic [IDX_W-1:0] park_q, park_d;
`endif

  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    gnt_valid_d   = gnt_valid_q;
    bus_busy_d    = bus_busy_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    release_grant = 1'b0;
`ifdef PCI_ARB_PARK_EN
    park_d        = park_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StGrant;
        end else begin
`ifdef PCI_ARB_PARK_EN
          gnt_idx_d   = park_q;
          gnt_valid_d = 1'b1;
`else
          gnt_valid_d = 1'b0;
`endif
        end
      end

      StGrant: begin
        if (!frame_n) begin
          state_d    = StBusy;
          bus_busy_d = 1'b1;
        end else if (req_n[gnt_idx_q]) begin
          release_grant = 1'b1;
        end else if (cnt_q == CntLast) begin
          release_grant = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StBusy: begin
        if (frame_n && irdy_n) begin
          release_grant = 1'b1;
          bus_busy_d    = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (release_grant) begin
      gnt_valid_d = 1'b0;
      last_d      = gnt_idx_q;
      state_d     = StIdle;
`ifdef PCI_ARB_PARK_EN
      park_d      = gnt_idx_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      bus_busy_q  <= 1'b0;
      cnt_q       <= '0;
      last_q      <= IDX_W'(NUM_AGENTS - 1);
`ifdef PCI_ARB_PARK_EN
      park_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      bus_busy_q  <= bus_busy_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
`ifdef PCI_ARB_PARK_EN
      park_q      <= park_d;
`endif
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_pci_req_arbiter.sv
// Scoreboard bench for pci_req_arbiter; expectations follow PCI_ARB_PARK_EN when defined.
module tb_pci_req_arbiter;

`ifdef PCI_ARB_PARK_EN
  localparam bit Park = 1'b1;
`else
  localparam bit Park = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       bus_busy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic [3:0] req;
    logic       f;
    logic       i;
    logic       v;
    logic [1:0] idx;
    logic       busy;
    bit         ci;
  } step_t;

  step_t stim_q[$];
  step_t exp_q[$];

  always #5 clk = ~clk;

  pci_req_arbiter #(.GNT_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_n     (req_n),
    .frame_n   (frame_n),
    .irdy_n    (irdy_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .bus_busy  (bus_busy)
  );

  function automatic void add(string tag, logic rst, logic [3:0] req, logic f, logic i,
                              logic v, logic [1:0] idx, logic busy, bit ci);
    step_t s;
    s.tag = tag; s.rst = rst; s.req = req; s.f = f; s.i = i;
    s.v = v; s.idx = idx; s.busy = busy; s.ci = ci;
    stim_q.push_back(s);
  endfunction

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic f, input logic i);
    reset   = r;
    req_n   = rq;
    frame_n = f;
    irdy_n  = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step_t s, e;
    add("rst_hold", 1, 4'b1111, 1, 1, 0, 0, 0, 1);
    add("rst_hold2", 1, 4'b0000, 0, 0, 0, 0, 0, 1);
    add("rst_first_idle", 0, 4'b1111, 1, 1, Park, 0, 0, Park);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL reset/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_single_request();
    step_t s, e;
    add("grant1", 0, 4'b1101, 1, 1, 1, 1, 0, 1);
    add("frame_busy", 0, 4'b1101, 0, 1, 1, 1, 1, 1);
    add("busy_hold", 0, 4'b1101, 0, 0, 1, 1, 1, 1);
    add("bus_idle", 0, 4'b1111, 1, 1, 0, 1, 0, 0);
    add("after_idle", 0, 4'b1111, 1, 1, Park, 1, 0, Park);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL single/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_fairness();
    step_t s, e;
    logic [1:0] k;
    add("rst", 1, 4'b0000, 1, 1, 0, 0, 0, 1);
    for (int n = 0; n < 5; n++) begin
      k = 2'(n);
      add("grant", 0, 4'b0000, 1, 1, 1, k, 0, 1);
      add("busy1", 0, 4'b0000, 0, 0, 1, k, 1, 1);
      add("busy2", 0, 4'b0000, 0, 1, 1, k, 1, 1);
      add("end", 0, 4'b0000, 1, 1, 0, k, 0, 0);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL fairness/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    step_t s, e;
    add("rst", 1, 4'b1111, 1, 1, 0, 0, 0, 1);
    for (int n = 0; n < 16; n++) add("held", 0, 4'b1110, 1, 1, 1, 0, 0, 1);
    add("revoked", 0, 4'b1110, 1, 1, 0, 0, 0, 0);
    add("regrant0", 0, 4'b1110, 1, 1, 1, 0, 0, 1);
    add("withdraw", 0, 4'b1111, 1, 1, 0, 0, 0, 0);
    add("idle", 0, 4'b1111, 1, 1, Park, 0, 0, Park);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL timeout/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    step_t s, e;
    add("rst", 1, 4'b1111, 1, 1, 0, 0, 0, 1);
    for (int n = 0; n < 16; n++) add("held", 0, 4'b1110, 1, 1, 1, 0, 0, 1);
    // Counter is at its last value here: FRAME# must win over the timeout.
    add("frame_vs_timeout", 0, 4'b1110, 0, 1, 1, 0, 1, 1);
    add("end", 0, 4'b1111, 1, 1, 0, 0, 0, 0);
    add("grant1", 0, 4'b1101, 1, 1, 1, 1, 0, 1);
    add("frame_vs_withdraw", 0, 4'b1111, 0, 1, 1, 1, 1, 1);
    add("end2", 0, 4'b1111, 1, 1, 0, 1, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL simul/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_withdraw_reset();
    step_t s, e;
    add("rst", 1, 4'b1111, 1, 1, 0, 0, 0, 1);
    add("grant2", 0, 4'b1011, 1, 1, 1, 2, 0, 1);
    add("withdraw", 0, 4'b1111, 1, 1, 0, 2, 0, 0);
    add("idle", 0, 4'b1111, 1, 1, Park, 2, 0, Park);
    add("regrant2", 0, 4'b1011, 1, 1, 1, 2, 0, 1);
    add("busy", 0, 4'b1011, 0, 1, 1, 2, 1, 1);
    add("rst_in_busy", 1, 4'b1011, 0, 1, 0, 0, 0, 1);
    add("idle_after_rst", 0, 4'b1111, 1, 1, Park, 0, 0, Park);
    add("prio0_after_rst", 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL withdraw/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  task automatic test_park();
    step_t s, e;
    add("rst", 1, 4'b1111, 1, 1, 0, 0, 0, 1);
    add("park0", 0, 4'b1111, 1, 1, Park, 0, 0, Park);
    add("park0_hold", 0, 4'b1111, 1, 1, Park, 0, 0, Park);
    add("grant3", 0, 4'b0111, 1, 1, 1, 3, 0, 1);
    add("busy", 0, 4'b0111, 0, 1, 1, 3, 1, 1);
    add("end", 0, 4'b1111, 1, 1, 0, 3, 0, 0);
    add("park3", 0, 4'b1111, 1, 1, Park, 3, 0, Park);
    add("park3_hold", 0, 4'b1111, 1, 1, Park, 3, 0, Park);
    add("parked_req", 0, 4'b0111, 1, 1, 1, 3, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(s);
      cyc(s.rst, s.req, s.f, s.i);
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.v || bus_busy !== e.busy || (e.ci && gnt_idx !== e.idx))
        $display("FAIL park/%s: got v=%b idx=%0d busy=%b, expected v=%b idx=%0d busy=%b",
                 e.tag, gnt_valid, gnt_idx, bus_busy, e.v, e.idx, e.busy);
      else passed++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    req_n   = 4'b1111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_request();
    test_fairness();
    test_timeout();
    test_simultaneous();
    test_withdraw_reset();
    test_park();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/pci_req_arbiter.md
# pci_req_arbiter

Four-agent PCI bus arbiter that turns active-low REQ# lines into a registered 2-bit grant index.
- Round-robin fairness across the four agents.
- Watches FRAME#/IRDY# to track bus ownership.
- Revokes unused grants after a timeout.

It sits between the agents' REQ# pins and the grant decode logic, which expands `gnt_idx`/`gnt_valid` into per-agent active-low GNT#.

## Interface
Parameters:
- GNT_TIMEOUT, 16, cycles an agent may hold an unused grant (FRAME# still high) before it is revoked; legal range 2..31.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_n  in  4  per-agent request, active low; bit i = agent i.
- frame_n  in  1  PCI FRAME#, active low.
- irdy_n  in  1  PCI IRDY#, active low.
- gnt_idx  out  2  index of the granted agent, registered.
- gnt_valid  out  1  grant asserted for agent `gnt_idx`, registered.
- bus_busy  out  1  high while a granted transaction is in progress (state BUSY).

## Operation
- Reset values:
  - gnt_idx=0, gnt_valid=0, bus_busy=0.
  - State IDLE, timeout counter 0.
  - Last-owner pointer `last`=3, so agent 0 has top priority first.
- Winner selection: scan agents `last+1, last+2, last+3, last` (mod 4). The first one with req_n low wins.
- States:
  - IDLE: if any req_n low, then gnt_idx←winner, gnt_valid←1, counter←0, go to GRANT. Otherwise stay in IDLE (grant behaviour set by Configuration).
  - GRANT (checked in priority order):
    1. frame_n low: go to BUSY, bus_busy←1.
    2. Otherwise req_n[gnt_idx] high (agent withdrew): gnt_valid←0, last←gnt_idx, go to IDLE.
    3. Otherwise counter == GNT_TIMEOUT-1: revoke (gnt_valid←0, last←gnt_idx), go to IDLE.
    4. Otherwise counter+1.
  - BUSY: hold gnt_idx and gnt_valid. When frame_n and irdy_n are both high (bus idle): last←gnt_idx, gnt_valid←0, bus_busy←0, go to IDLE.
- An owner's req_n change during BUSY is ignored.
- The counter saturates and never wraps. It is cleared on every entry to GRANT.
- `last` changes only on leaving GRANT or BUSY. Re-arbitration therefore always rotates past the previous owner.

## Timing
- Request to grant: req_n sampled low in IDLE at edge N gives gnt_valid=1 after edge N (1-cycle latency).
- Timeout: with no FRAME#, gnt_valid drops after exactly GNT_TIMEOUT cycles of gnt_valid=1.
- Simultaneous events in GRANT:
  - frame_n low wins over timeout.
  - frame_n low wins over req withdrawal.
- Transaction end: bus idle sampled at edge M means gnt_valid=0 after M. The earliest next grant is after edge M+1, which guarantees one idle grant-free cycle between owners.
- Reset asserted in any state returns all outputs to their reset values on that edge, discarding any in-flight grant.

## Configuration
- Macro `PCI_ARB_PARK_EN` (bus parking):
  - Defined: in IDLE with no requests, gnt_valid=1 and gnt_idx=`last`. After reset it parks on agent 0 from the first post-reset edge. A new winner replaces the parked index with the same 1-cycle latency. A request from the parked agent moves to GRANT without any gnt_valid low cycle.
  - Undefined: gnt_valid=0 whenever the state is IDLE.

## Structure
- Shared package `pci_arb_pkg` holds:
  - the state enum typedef (IDLE, GRANT, BUSY);
  - the agent-count constant NUM_AGENTS=4;
  - the index-width constant IDX_W=2;
  - the default GNT_TIMEOUT.
- One sub-module: `rr_pick4`, a combinational round-robin priority finder with inputs req (active high) and last, and outputs winner and any.

## Test plan
- Single request: reset, then req_n=4'b1101 → after 1 edge gnt_idx=1, gnt_valid=1. Then frame_n low → bus_busy=1. Then frame_n=irdy_n=1 → gnt_valid=0 next edge.
- Fairness: req_n=4'b0000 held, each grant runs a 2-cycle transaction → grant order 0,1,2,3,0.
- Timeout: req_n=4'b1110, frame_n held high → gnt_valid high for exactly 16 cycles, then low, then re-granted to agent 0 one cycle later.
- Simultaneous events in GRANT on the last count: frame_n falls together with timeout → state BUSY, gnt_valid stays 1.
- Withdrawal and reset:
  - Agent 2 granted, then req_n[2] rises before FRAME# → gnt_valid=0 next edge.
  - Reset pulsed during BUSY → gnt_valid=0, bus_busy=0, gnt_idx=0 after that edge.
- With `PCI_ARB_PARK_EN`: no requests after reset → gnt_valid=1, gnt_idx=0. After agent 3 completes a transaction, the grant parks with gnt_idx=3.
